controle_pc_fsm: RTL and testbench
==================================

Name: controle_pc_fsm

Overview:
Multicycle control FSM that sequences instruction fetch, decode and every PC-changing instruction in the MIPS multicycle datapath. It drives the PC write enables consumed by the branch-decision circuit: EscrevePC, EscrevePCCondEQ, EscrevePCCondNE and EscrevePCCond. It also drives PC source, ALU operand selects and IR load. All non-control-flow instructions are handed off to the execution controller through a start/done handshake.

Parameters:
ESTADO_W, 4, width of the state register and of the debug state output.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
opcode  input  6  IR[31:26].
funct  input  6  IR[5:0].
rt  input  5  IR[20:16]; selects the REGIMM variant.
mem_ready  input  1  instruction memory data valid.
exec_done  input  1  execution controller finished the non-branch instruction.
MemRead  output  1  instruction memory read strobe.
IREscreve  output  1  IR load enable.
EscrevePC  output  1  unconditional PC write.
EscrevePCCondEQ  output  1  PC write if zero (BEQ).
EscrevePCCondNE  output  1  PC write if !zero (BNE).
EscrevePCCond  output  1  PC write on a magnitude compare (REGIMM, BGTZ, BLEZ).
OrigPC  output  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target, 11 register A.
ALUSrcA  output  1  0 = PC, 1 = register A.
ALUSrcB  output  2  00 = B, 01 = const 4, 10 = imm, 11 = imm<<2.
ALUOp  output  2  00 = add, 01 = sub/compare.
RegWrite  output  1  register file write (link only).
RegDst  output  2  10 = $31.
MemtoReg  output  2  10 = PC.
exec_start  output  1  one-cycle handoff pulse.
estado  output  ESTADO_W  current state, for debug.

Behaviour:
- Reset: asynchronous and active-high. On assertion: state = RESET and every output = 0, whatever state the FSM was in (including mid-fetch or waiting on exec_done).
- All outputs are Moore-style: a combinational function of state only. Exceptions: IREscreve and EscrevePC in BUSCA are also gated by mem_ready.
- RESET: all outputs 0. Unconditional transition to BUSCA after one clock with reset low.
- BUSCA: MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, OrigPC=00.
  - mem_ready=0: hold BUSCA, IREscreve=0, EscrevePC=0.
  - mem_ready=1: IREscreve=1, EscrevePC=1 (PC<=PC+4), next state DECODIFICA.
- DECODIFICA: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state:
  - opcode 04/05/06/07 -> DESVIO.
  - opcode 01 with rt in {00,01,10h,11h} -> DESVIO.
  - opcode 02/03 -> SALTO.
  - opcode 00 with funct 08 -> JR.
  - anything else, including 01 with any other rt -> EXEC_INICIO.
- DESVIO (1 cycle): ALUSrcA=1, ALUSrcB=00, ALUOp=01, OrigPC=01.
  - Exactly one enable is asserted: EQ for 04, NE for 05, Cond for 01/06/07.
  - Next state BUSCA. The taken/not-taken decision belongs to the branch-decision circuit, not to this block.
- SALTO (1 cycle): EscrevePC=1, OrigPC=10 -> BUSCA.
- JR (1 cycle): EscrevePC=1, OrigPC=11 -> BUSCA.
- EXEC_INICIO (1 cycle): exec_start=1 -> EXEC_ESPERA.
- EXEC_ESPERA: all outputs 0. Hold until exec_done=1, then -> BUSCA. exec_done is ignored in every other state.
- Never more than one of the four PC enables is high in the same cycle.
- Unused state encodings go to BUSCA on the next clock with all outputs 0.
- Latency:
  - branch/J/JR: 3 cycles with a zero-wait fetch.
  - handed-off instruction: 4 + exec latency cycles.

Optional Feature:
BRANCH_LINK_EN
- Defined: adds state LINK (1 cycle) with RegWrite=1, RegDst=10, MemtoReg=10.
  - DECODIFICA routes opcode 03, and opcode 01 with rt 10h/11h, to LINK first.
  - LINK then goes to SALTO (for 03) or DESVIO (for 01).
  - $31 is written whether or not the branch is taken.
- Undefined: no LINK state. JAL behaves as J; BLTZAL/BGEZAL behave as BLTZ/BGEZ. RegWrite, RegDst and MemtoReg are tied to 0.

Decomposition:
- Package controle_pkg holds:
  - the state enum;
  - opcode constants (OP_RTYPE, OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ) and FUNCT_JR;
  - REGIMM rt constants;
  - OrigPC, ALUSrcB and ALUOp encodings.
- One combinational sub-module, classifica_instr, maps opcode/funct/rt to a class: DESVIO, SALTO, JR, LINK_FLAG, EXEC.

Test Plan:
- Reset asserted mid-EXEC_ESPERA -> estado=RESET and all outputs 0 in the same cycle; BUSCA one cycle after release.
- Fetch with mem_ready low 3 cycles, then high -> MemRead=1 for 4 cycles; IREscreve=EscrevePC=1 only in the 4th.
- opcode 04, then 05, then 06 -> in DESVIO, EscrevePCCondEQ, EscrevePCCondNE, EscrevePCCond respectively high with OrigPC=01, ALUOp=01; back in BUSCA the next cycle.
- opcode 00 funct 08 -> JR with EscrevePC=1, OrigPC=11. opcode 02 -> SALTO with OrigPC=10.
- opcode 23h (lw) -> exec_start pulses exactly 1 cycle; exec_done held low 5 cycles then high -> BUSCA next cycle. exec_done high during BUSCA is ignored.
- With BRANCH_LINK_EN, opcode 01 rt=11h -> LINK (RegWrite=1, RegDst=10, MemtoReg=10), then DESVIO with EscrevePCCond=1. Without the macro: straight to DESVIO, RegWrite stays 0.

Source files
------------

// File: rtl/controle_pc_fsm_pkg.sv
// controle_pkg: shared types and constants for the multicycle PC control FSM.
// Holds the state encoding, MIPS opcode/funct/rt constants, the datapath
// select encodings and the instruction-class type produced by classifica_instr.
// Optional feature macro: BRANCH_LINK_EN (consumed by controle_pc_fsm).
package controle_pkg;

  typedef enum logic [3:0] {
    ST_RESET       = 4'd0,
    ST_BUSCA       = 4'd1,
    ST_DECODIFICA  = 4'd2,
    ST_DESVIO      = 4'd3,
    ST_SALTO       = 4'd4,
    ST_JR          = 4'd5,
    ST_EXEC_INICIO = 4'd6,
    ST_EXEC_ESPERA = 4'd7,
    ST_LINK        = 4'd8
  } estado_e;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] FUNCT_JR  = 6'h08;

  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  localparam logic [1:0] ORIGPC_ALU    = 2'b00;
  localparam logic [1:0] ORIGPC_ALUOUT = 2'b01;
  localparam logic [1:0] ORIGPC_JUMP   = 2'b10;
  localparam logic [1:0] ORIGPC_REGA   = 2'b11;

  localparam logic [1:0] ALUB_REG     = 2'b00;
  localparam logic [1:0] ALUB_CONST4  = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;

  localparam logic [1:0] REGDST_RA   = 2'b10;
  localparam logic [1:0] MEMTOREG_PC = 2'b10;

  typedef enum logic [1:0] {
    CLS_EXEC   = 2'd0,
    CLS_DESVIO = 2'd1,
    CLS_SALTO  = 2'd2,
    CLS_JR     = 2'd3
  } classe_e;

  typedef struct packed {
    classe_e classe;
    logic    link;
  } classe_t;

  // Registered control word. 'busca' marks the fetch state so that
  // IREscreve/EscrevePC can be qualified by mem_ready outside the register.
  typedef struct packed {
    logic       mem_read;
    logic       busca;
    logic       pc_uncond;
    logic       pc_eq;
    logic       pc_ne;
    logic       pc_cond;
    logic [1:0] orig_pc;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       exec_start;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
  } ctrl_t;

endpackage

// File: rtl/controle_pc_fsm_if.sv
// controle_pc_fsm_if: instruction fields, handshakes and datapath controls
// between the PC control FSM (master) and the datapath/execution side (slave).
// Parameter ESTADO_W sets the width of the debug state bus.
interface controle_pc_fsm_if #(parameter int ESTADO_W = 4) ();
  logic [5:0]          opcode;
  logic [5:0]          funct;
  logic [4:0]          rt;
  logic                mem_ready;
  logic                exec_done;
  logic                MemRead;
  logic                IREscreve;
  logic                EscrevePC;
  logic                EscrevePCCondEQ;
  logic                EscrevePCCondNE;
  logic                EscrevePCCond;
  logic [1:0]          OrigPC;
  logic                ALUSrcA;
  logic [1:0]          ALUSrcB;
  logic [1:0]          ALUOp;
  logic                RegWrite;
  logic [1:0]          RegDst;
  logic [1:0]          MemtoReg;
  logic                exec_start;
  logic [ESTADO_W-1:0] estado;

  modport master (
    input  opcode, funct, rt, mem_ready, exec_done,
    output MemRead, IREscreve, EscrevePC, EscrevePCCondEQ, EscrevePCCondNE,
           EscrevePCCond, OrigPC, ALUSrcA, ALUSrcB, ALUOp, RegWrite, RegDst,
           MemtoReg, exec_start, estado
  );

  modport slave (
    output opcode, funct, rt, mem_ready, exec_done,
    input  MemRead, IREscreve, EscrevePC, EscrevePCCondEQ, EscrevePCCondNE,
           EscrevePCCond, OrigPC, ALUSrcA, ALUSrcB, ALUOp, RegWrite, RegDst,
           MemtoReg, exec_start, estado
  );
endinterface

// File: rtl/controle_pc_fsm_classifica_instr.sv
// classifica_instr: purely combinational instruction classifier.
// Ports: opcode_i/funct_i/rt_i (IR fields) -> classe_o (class + link flag).
// REGIMM encodings outside BLTZ/BGEZ/BLTZAL/BGEZAL are not branches here and
// go to the execution controller like any other instruction.
module classifica_instr
  import controle_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic [4:0] rt_i,
  output classe_t    classe_o
);

  always_comb begin
    classe_o.classe = CLS_EXEC;
    classe_o.link   = 1'b0;
    case (opcode_i)
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: classe_o.classe = CLS_DESVIO;
      OP_REGIMM: begin
        if (rt_i == RT_BLTZ || rt_i == RT_BGEZ) begin
          classe_o.classe = CLS_DESVIO;
        end else if (rt_i == RT_BLTZAL || rt_i == RT_BGEZAL) begin
          classe_o.classe = CLS_DESVIO;
          classe_o.link   = 1'b1;
        end
      end
      OP_J:   classe_o.classe = CLS_SALTO;
      OP_JAL: begin
        classe_o.classe = CLS_SALTO;
        classe_o.link   = 1'b1;
      end
      OP_RTYPE: begin
        if (funct_i == FUNCT_JR) classe_o.classe = CLS_JR;
      end
      default: classe_o.classe = CLS_EXEC;
    endcase
  end

endmodule

// File: rtl/controle_pc_fsm.sv
// controle_pc_fsm: multicycle MIPS control FSM for fetch, decode and every
// PC-changing instruction; other instructions are handed to the execution
// controller through exec_start/exec_done.
// Ports: clk, reset (async, active-high), bus (controle_pc_fsm_if.master:
// IR fields, mem_ready, exec_done in; PC enables, selects, IR load,
// exec_start and debug state out).
// Macro BRANCH_LINK_EN: adds the LINK state that writes $31 for JAL/BLTZAL/
// BGEZAL; without it those behave as J/BLTZ/BGEZ and the link controls stay 0.
module controle_pc_fsm
  import controle_pkg::*;
#(
  parameter int ESTADO_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  controle_pc_fsm_if.master bus
);

  estado_e state_q, state_d;
  ctrl_t   ctrl_q, ctrl_d;
  classe_t cls;

  classifica_instr u_classifica (
    .opcode_i (bus.opcode),
    .funct_i  (bus.funct),
    .rt_i     (bus.rt),
    .classe_o (cls)
  );

`ifndef BRANCH_LINK_EN
  logic unused_link;
  assign unused_link = cls.link;
`endif

  always_comb begin
    state_d = ST_BUSCA;
    case (state_q)
      ST_RESET: state_d = ST_BUSCA;
      ST_BUSCA: state_d = bus.mem_ready ? ST_DECODIFICA : ST_BUSCA;
      ST_DECODIFICA: begin
        case (cls.classe)
          CLS_DESVIO: state_d = ST_DESVIO;
          CLS_SALTO:  state_d = ST_SALTO;
          CLS_JR:     state_d = ST_JR;
          default:    state_d = ST_EXEC_INICIO;
        endcase
`ifdef BRANCH_LINK_EN
        if (cls.link) state_d = ST_LINK;
`endif
      end
      ST_DESVIO, ST_SALTO, ST_JR: state_d = ST_BUSCA;
      ST_EXEC_INICIO: state_d = ST_EXEC_ESPERA;
      ST_EXEC_ESPERA: state_d = bus.exec_done ? ST_BUSCA : ST_EXEC_ESPERA;
`ifdef BRANCH_LINK_EN
      ST_LINK: state_d = (cls.classe == CLS_SALTO) ? ST_SALTO : ST_DESVIO;
`endif
      default: state_d = ST_BUSCA;
    endcase
  end

  // Outputs are decoded from the state being entered and registered, so they
  // equal a Moore function of the current state. The IR is already loaded
  // when DESVIO is entered, so the opcode picks the single branch enable.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      ST_BUSCA: begin
        ctrl_d.mem_read  = 1'b1;
        ctrl_d.busca     = 1'b1;
        ctrl_d.alu_src_b = ALUB_CONST4;
        ctrl_d.alu_op    = ALUOP_ADD;
        ctrl_d.orig_pc   = ORIGPC_ALU;
      end
      ST_DECODIFICA: begin
        ctrl_d.alu_src_b = ALUB_IMM_SH2;
        ctrl_d.alu_op    = ALUOP_ADD;
      end
      ST_DESVIO: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = ALUB_REG;
        ctrl_d.alu_op    = ALUOP_SUB;
        ctrl_d.orig_pc   = ORIGPC_ALUOUT;
        if (bus.opcode == OP_BEQ)      ctrl_d.pc_eq   = 1'b1;
        else if (bus.opcode == OP_BNE) ctrl_d.pc_ne   = 1'b1;
        else                           ctrl_d.pc_cond = 1'b1;
      end
      ST_SALTO: begin
        ctrl_d.pc_uncond = 1'b1;
        ctrl_d.orig_pc   = ORIGPC_JUMP;
      end
      ST_JR: begin
        ctrl_d.pc_uncond = 1'b1;
        ctrl_d.orig_pc   = ORIGPC_REGA;
      end
      ST_EXEC_INICIO: ctrl_d.exec_start = 1'b1;
`ifdef BRANCH_LINK_EN
      ST_LINK: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.reg_dst    = REGDST_RA;
        ctrl_d.mem_to_reg = MEMTOREG_PC;
      end
`endif
      default: ctrl_d = '0;
    endcase
  end

  // State and control word registers; reset clears every output at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RESET;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus.MemRead         = ctrl_q.mem_read;
  assign bus.IREscreve       = ctrl_q.busca & bus.mem_ready;
  assign bus.EscrevePC       = ctrl_q.pc_uncond | (ctrl_q.busca & bus.mem_ready);
  assign bus.EscrevePCCondEQ = ctrl_q.pc_eq;
  assign bus.EscrevePCCondNE = ctrl_q.pc_ne;
  assign bus.EscrevePCCond   = ctrl_q.pc_cond;
  assign bus.OrigPC          = ctrl_q.orig_pc;
  assign bus.ALUSrcA         = ctrl_q.alu_src_a;
  assign bus.ALUSrcB         = ctrl_q.alu_src_b;
  assign bus.ALUOp           = ctrl_q.alu_op;
  assign bus.RegWrite        = ctrl_q.reg_write;
  assign bus.RegDst          = ctrl_q.reg_dst;
  assign bus.MemtoReg        = ctrl_q.mem_to_reg;
  assign bus.exec_start      = ctrl_q.exec_start;
  assign bus.estado          = ESTADO_W'(state_q);

endmodule

// File: tb/tb_controle_pc_fsm.sv
// tb_controle_pc_fsm: directed self-checking bench for controle_pc_fsm.
// Each task walks one scenario and compares {estado, control word} against
// hand-built constants. Honors BRANCH_LINK_EN for the link scenarios.
module tb_controle_pc_fsm;
  import controle_pkg::*;

  logic clk;
  logic reset;
  int   nCompared;
  int   nMismatched;

  controle_pc_fsm_if #(.ESTADO_W(4)) bus ();

  controle_pc_fsm #(.ESTADO_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Control word layout (MSB first): MemRead, IREscreve, EscrevePC, EQ, NE,
  // Cond, OrigPC[2], ALUSrcA, ALUSrcB[2], ALUOp[2], RegWrite, RegDst[2],
  // MemtoReg[2], exec_start.
  localparam logic [18:0] V_ZERO       = 19'b0_0_0_0_0_0_00_0_00_00_0_00_00_0;
  localparam logic [18:0] V_FETCH_WAIT = 19'b1_0_0_0_0_0_00_0_01_00_0_00_00_0;
  localparam logic [18:0] V_FETCH_GO   = 19'b1_1_1_0_0_0_00_0_01_00_0_00_00_0;
  localparam logic [18:0] V_DECODE     = 19'b0_0_0_0_0_0_00_0_11_00_0_00_00_0;
  localparam logic [18:0] V_BEQ        = 19'b0_0_0_1_0_0_01_1_00_01_0_00_00_0;
  localparam logic [18:0] V_BNE        = 19'b0_0_0_0_1_0_01_1_00_01_0_00_00_0;
  localparam logic [18:0] V_BCOND      = 19'b0_0_0_0_0_1_01_1_00_01_0_00_00_0;
  localparam logic [18:0] V_SALTO      = 19'b0_0_1_0_0_0_10_0_00_00_0_00_00_0;
  localparam logic [18:0] V_JR         = 19'b0_0_1_0_0_0_11_0_00_00_0_00_00_0;
  localparam logic [18:0] V_EXEC_START = 19'b0_0_0_0_0_0_00_0_00_00_0_00_00_1;
  localparam logic [18:0] V_LINK       = 19'b0_0_0_0_0_0_00_0_00_00_1_10_10_0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [22:0] snap();
    return {bus.estado, bus.MemRead, bus.IREscreve, bus.EscrevePC,
            bus.EscrevePCCondEQ, bus.EscrevePCCondNE, bus.EscrevePCCond,
            bus.OrigPC, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.RegWrite,
            bus.RegDst, bus.MemtoReg, bus.exec_start};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in a freshly entered BUSCA; leaves the FSM in DECODIFICA.
  task automatic doFetch(input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rtv, input int waits);
    for (int i = 0; i < waits; i++) begin
      bus.mem_ready = 1'b0;
      #1;
      nCompared++;
      if (snap() !== {4'(ST_BUSCA), V_FETCH_WAIT}) begin
        nMismatched++;
        $display("[TB] FAIL fetch_wait[%0d]: got %h expected %h", i, snap(), {4'(ST_BUSCA), V_FETCH_WAIT});
      end
      tick();
    end
    bus.opcode    = op;
    bus.funct     = fn;
    bus.rt        = rtv;
    bus.mem_ready = 1'b1;
    #1;
    nCompared++;
    if (snap() !== {4'(ST_BUSCA), V_FETCH_GO}) begin
      nMismatched++;
      $display("[TB] FAIL fetch_go op=%h: got %h expected %h", op, snap(), {4'(ST_BUSCA), V_FETCH_GO});
    end
    tick();
    bus.mem_ready = 1'b0;
    nCompared++;
    if (snap() !== {4'(ST_DECODIFICA), V_DECODE}) begin
      nMismatched++;
      $display("[TB] FAIL decode op=%h: got %h expected %h", op, snap(), {4'(ST_DECODIFICA), V_DECODE});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    nCompared++;
    if (snap() !== {4'(ST_RESET), V_ZERO}) begin
      nMismatched++;
      $display("[TB] FAIL reset_hold: got %h expected %h", snap(), {4'(ST_RESET), V_ZERO});
    end
    reset = 1'b0;
    #1;
    nCompared++;
    if (snap() !== {4'(ST_RESET), V_ZERO}) begin
      nMismatched++;
      $display("[TB] FAIL reset_release: got %h expected %h", snap(), {4'(ST_RESET), V_ZERO});
    end
    tick();
    nCompared++;
    if (snap() !== {4'(ST_BUSCA), V_FETCH_WAIT}) begin
      nMismatched++;
      $display("[TB] FAIL reset_to_busca: got %h expected %h", snap(), {4'(ST_BUSCA), V_FETCH_WAIT});
    end
  endtask

  task automatic test_fetch_wait();
    doFetch(OP_J, 6'h00, 5'h00, 3);
    tick();
    nCompared++;
    if (snap() !== {4'(ST_SALTO), V_SALTO}) begin
      nMismatched++;
      $display("[TB] FAIL fetch_wait_salto: got %h expected %h", snap(), {4'(ST_SALTO), V_SALTO});
    end
    tick();
  endtask

  task automatic test_branches();
    logic [5:0]  ops  [5] = '{6'h04, 6'h05, 6'h06, 6'h07, 6'h01};
    logic [18:0] exps [5] = '{V_BEQ, V_BNE, V_BCOND, V_BCOND, V_BCOND};
    for (int i = 0; i < 5; i++) begin
      doFetch(ops[i], 6'h00, 5'h01, 0);
      tick();
      nCompared++;
      if (snap() !== {4'(ST_DESVIO), exps[i]}) begin
        nMismatched++;
        $display("[TB] FAIL desvio op=%h: got %h expected %h", ops[i], snap(), {4'(ST_DESVIO), exps[i]});
      end
      tick();
      nCompared++;
      if (snap() !== {4'(ST_BUSCA), V_FETCH_WAIT}) begin
        nMismatched++;
        $display("[TB] FAIL desvio_return op=%h: got %h expected %h", ops[i], snap(), {4'(ST_BUSCA), V_FETCH_WAIT});
      end
    end
  endtask

  task automatic test_jumps();
    doFetch(OP_RTYPE, FUNCT_JR, 5'h00, 0);
    tick();
    nCompared++;
    if (snap() !== {4'(ST_JR), V_JR}) begin
      nMismatched++;
      $display("[TB] FAIL jr: got %h expected %h", snap(), {4'(ST_JR), V_JR});
    end
    tick();
    doFetch(OP_J, 6'h00, 5'h00, 0);
    tick();
    nCompared++;
    if (snap() !== {4'(ST_SALTO), V_SALTO}) begin
      nMismatched++;
      $display("[TB] FAIL j: got %h expected %h", snap(), {4'(ST_SALTO), V_SALTO});
    end
    tick();
    nCompared++;
    if (snap() !== {4'(ST_BUSCA), V_FETCH_WAIT}) begin
      nMismatched++;
      $display("[TB] FAIL j_return: got %h expected %h", snap(), {4'(ST_BUSCA), V_FETCH_WAIT});
    end
  endtask

  task automatic test_exec();
    bus.exec_done = 1'b0;
    doFetch(6'h23, 6'h00, 5'h00, 0);
    tick();
    nCompared++;
    if (snap() !== {4'(ST_EXEC_INICIO), V_EXEC_START}) begin
      nMismatched++;
      $display("[TB] FAIL exec_start: got %h expected %h", snap(), {4'(ST_EXEC_INICIO), V_EXEC_START});
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      nCompared++;
      if (snap() !== {4'(ST_EXEC_ESPERA), V_ZERO}) begin
        nMismatched++;
        $display("[TB] FAIL exec_wait[%0d]: got %h expected %h", i, snap(), {4'(ST_EXEC_ESPERA), V_ZERO});
      end
    end
    bus.exec_done = 1'b1;
    tick();
    nCompared++;
    if (snap() !== {4'(ST_BUSCA), V_FETCH_WAIT}) begin
      nMismatched++;
      $display("[TB] FAIL exec_done: got %h expected %h", snap(), {4'(ST_BUSCA), V_FETCH_WAIT});
    end
    tick();
    nCompared++;
    if (snap() !== {4'(ST_BUSCA), V_FETCH_WAIT}) begin
      nMismatched++;
      $display("[TB] FAIL exec_done_ignored: got %h expected %h", snap(), {4'(ST_BUSCA), V_FETCH_WAIT});
    end
    bus.exec_done = 1'b0;
  endtask

  task automatic test_link();
    doFetch(OP_REGIMM, 6'h00, 5'h11, 0);
    tick();
`ifdef BRANCH_LINK_EN
    nCompared++;
    if (snap() !== {4'(ST_LINK), V_LINK}) begin
      nMismatched++;
      $display("[TB] FAIL bgezal_link: got %h expected %h", snap(), {4'(ST_LINK), V_LINK});
    end
    tick();
`endif
    nCompared++;
    if (snap() !== {4'(ST_DESVIO), V_BCOND}) begin
      nMismatched++;
      $display("[TB] FAIL bgezal_desvio: got %h expected %h", snap(), {4'(ST_DESVIO), V_BCOND});
    end
    tick();
    doFetch(OP_JAL, 6'h00, 5'h00, 0);
    tick();
`ifdef BRANCH_LINK_EN
    nCompared++;
    if (snap() !== {4'(ST_LINK), V_LINK}) begin
      nMismatched++;
      $display("[TB] FAIL jal_link: got %h expected %h", snap(), {4'(ST_LINK), V_LINK});
    end
    tick();
`endif
    nCompared++;
    if (snap() !== {4'(ST_SALTO), V_SALTO}) begin
      nMismatched++;
      $display("[TB] FAIL jal_salto: got %h expected %h", snap(), {4'(ST_SALTO), V_SALTO});
    end
    tick();
    doFetch(OP_REGIMM, 6'h00, 5'h02, 0);
    tick();
    nCompared++;
    if (snap() !== {4'(ST_EXEC_INICIO), V_EXEC_START}) begin
      nMismatched++;
      $display("[TB] FAIL regimm_other: got %h expected %h", snap(), {4'(ST_EXEC_INICIO), V_EXEC_START});
    end
    tick();
    bus.exec_done = 1'b1;
    tick();
    bus.exec_done = 1'b0;
    nCompared++;
    if (snap() !== {4'(ST_BUSCA), V_FETCH_WAIT}) begin
      nMismatched++;
      $display("[TB] FAIL regimm_other_return: got %h expected %h", snap(), {4'(ST_BUSCA), V_FETCH_WAIT});
    end
  endtask

  task automatic test_reset_mid_wait();
    doFetch(6'h23, 6'h00, 5'h00, 0);
    tick();
    tick();
    nCompared++;
    if (snap() !== {4'(ST_EXEC_ESPERA), V_ZERO}) begin
      nMismatched++;
      $display("[TB] FAIL pre_reset_wait: got %h expected %h", snap(), {4'(ST_EXEC_ESPERA), V_ZERO});
    end
    reset = 1'b1;
    #1;
    nCompared++;
    if (snap() !== {4'(ST_RESET), V_ZERO}) begin
      nMismatched++;
      $display("[TB] FAIL async_reset: got %h expected %h", snap(), {4'(ST_RESET), V_ZERO});
    end
    reset = 1'b0;
    tick();
    nCompared++;
    if (snap() !== {4'(ST_BUSCA), V_FETCH_WAIT}) begin
      nMismatched++;
      $display("[TB] FAIL async_reset_busca: got %h expected %h", snap(), {4'(ST_BUSCA), V_FETCH_WAIT});
    end
  endtask

  initial begin
    nCompared     = 0;
    nMismatched   = 0;
    reset         = 1'b1;
    bus.opcode    = 6'h00;
    bus.funct     = 6'h00;
    bus.rt        = 5'h00;
    bus.mem_ready = 1'b0;
    bus.exec_done = 1'b0;
    test_reset();
    test_fetch_wait();
    test_branches();
    test_jumps();
    test_exec();
    test_link();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
